// File: rtl/fifo_1r1w_sync.sv
// fifo_1r1w_sync: first-word-fall-through ready/valid FIFO built around a 1R1W synchronous RAM
module ram_1r1w_sync #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 512,
  localparam int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

module fifo_1r1w_sync #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 512,
  localparam int unsigned AddrWidth = $clog2(Depth),
  localparam int unsigned CountWidth = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [Width-1:0]      data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [Width-1:0]      data_o,
  input  logic                  ready_i,
  output logic [CountWidth-1:0] count_o
);
  logic [AddrWidth-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] ram_cnt_q, ram_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  push, pop, rd;
  assign count_o = ram_cnt_q + CountWidth'(out_valid_q);
  assign ready_o = count_o != CountWidth'(Depth);
  assign valid_o = out_valid_q;
  assign push    = valid_i & ready_o;
  assign pop     = out_valid_q & ready_i;
  // ram_cnt must be nonzero at cycle start, so a read never hits this cycle's write address
  assign rd      = (ram_cnt_q != '0) & (~out_valid_q | pop);
  always_comb begin
    wr_ptr_d    = push ? (wr_ptr_q == AddrWidth'(Depth - 1) ? '0 : wr_ptr_q + AddrWidth'(1)) : wr_ptr_q;
    rd_ptr_d    = rd ? (rd_ptr_q == AddrWidth'(Depth - 1) ? '0 : rd_ptr_q + AddrWidth'(1)) : rd_ptr_q;
    ram_cnt_d   = ram_cnt_q + CountWidth'(push) - CountWidth'(rd);
    out_valid_d = rd | (out_valid_q & ~pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end
  ram_1r1w_sync #(.Width(Width), .Depth(Depth)) u_ram (
    .clk_i   (clk_i),
    .rst_i   (~rst_ni),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .re_i    (rd),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_o)
  );
endmodule

// File: tb/tb_fifo_1r1w_sync.sv
// tb_fifo_1r1w_sync: vector table plus scoreboard checks on a Depth=4 and a Depth=3 FIFO
module tb_fifo_1r1w_sync;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic v0 = 1'b0, r0 = 1'b0, vo0, ro0;
  logic v1 = 1'b0, r1 = 1'b0, vo1, ro1;
  logic [7:0] d0 = '0, d1 = '0, do0, do1;
  logic [2:0] cnt0;
  logic [1:0] cnt1;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] q0[$], q1[$];

  fifo_1r1w_sync #(.Width(8), .Depth(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v0), .data_i(d0), .ready_o(ro0),
    .valid_o(vo0), .data_o(do0), .ready_i(r0), .count_o(cnt0));
  fifo_1r1w_sync #(.Width(8), .Depth(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v1), .data_i(d1), .ready_o(ro1),
    .valid_o(vo1), .data_o(do1), .ready_i(r1), .count_o(cnt1));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // handshakes are stable from negedge to the next rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (v0 && ro0) q0.push_back(d0);
      if (vo0 && r0) begin
        if (q0.size() == 0) chk("sb4_underrun", 1, 0);
        else chk("sb4_data", int'(do0), int'(q0.pop_front()));
      end
      if (v1 && ro1) q1.push_back(d1);
      if (vo1 && r1) begin
        if (q1.size() == 0) chk("sb3_underrun", 1, 0);
        else chk("sb3_data", int'(do1), int'(q1.pop_front()));
      end
    end
  end
  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
  end

  task automatic s0(input logic v, input logic [7:0] d, input logic r);
    v0 = v; d0 = d; r0 = r;
    @(posedge clk);
    #1;
  endtask

  int ec1 = 0;
  task automatic s1(input logic v, input logic [7:0] d, input logic r);
    int push, pop;
    push = (v && ec1 != 3) ? 1 : 0;
    pop = (vo1 && r) ? 1 : 0;
    v1 = v; d1 = d; r1 = r;
    @(posedge clk);
    #1;
    ec1 = ec1 + push - pop;
    chk("w_count", int'(cnt1), ec1);
    chk("w_ready", int'(ro1), (ec1 != 3) ? 1 : 0);
    if (ec1 == 0) chk("w_empty_valid", int'(vo1), 0);
  endtask

  typedef struct {
    logic v; logic [7:0] d; logic r;
    logic ev; logic [7:0] ed; logic er; int ec;
  } vec_t;
  vec_t tbl[12];

  initial begin
    logic [7:0] dn;
    int got, gaps;
    tbl[0]  = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b1, 1};
    tbl[1]  = '{1'b1, 8'd2, 1'b0, 1'b1, 8'd1, 1'b1, 2};
    tbl[2]  = '{1'b1, 8'd3, 1'b0, 1'b1, 8'd1, 1'b1, 3};
    tbl[3]  = '{1'b1, 8'd4, 1'b0, 1'b1, 8'd1, 1'b0, 4};
    tbl[4]  = '{1'b1, 8'd5, 1'b0, 1'b1, 8'd1, 1'b0, 4};
    tbl[5]  = '{1'b1, 8'd5, 1'b1, 1'b1, 8'd2, 1'b1, 3};
    tbl[6]  = '{1'b1, 8'd5, 1'b0, 1'b1, 8'd2, 1'b0, 4};
    tbl[7]  = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd3, 1'b1, 3};
    tbl[8]  = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd4, 1'b1, 2};
    tbl[9]  = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 1'b1, 1};
    tbl[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 0};
    tbl[11] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 0};

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_valid", int'(vo0), 0);
      chk("rst_ready", int'(ro0), 1);
      chk("rst_count", int'(cnt0), 0);
      chk("rst_count3", int'(cnt1), 0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", int'(ro0), 1);
    chk("idle_valid", int'(vo0), 0);

    s0(1'b1, 8'hA5, 1'b1);
    chk("single_valid_e0", int'(vo0), 0);
    chk("single_count_e0", int'(cnt0), 1);
    s0(1'b0, 8'h00, 1'b1);
    chk("single_valid_e1", int'(vo0), 1);
    chk("single_data_e1", int'(do0), 8'hA5);
    s0(1'b0, 8'h00, 1'b1);
    chk("single_valid_end", int'(vo0), 0);
    chk("single_count_end", int'(cnt0), 0);

    for (int i = 0; i < 12; i++) begin
      s0(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), int'(vo0), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), int'(ro0), int'(tbl[i].er));
      chk($sformatf("tbl%0d_count", i), int'(cnt0), tbl[i].ec);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), int'(do0), int'(tbl[i].ed));
    end

    got = 0;
    gaps = 0;
    for (int k = 0; k < 25; k++) begin
      s0(k < 20, 8'(k), 1'b1);
      if (vo0) got++;
      else if (got > 0 && got < 20) gaps++;
    end
    chk("stream_words", got, 20);
    chk("stream_gaps", gaps, 0);

    dn = 8'h40;
    s1(1'b1, dn++, 1'b0);
    s1(1'b0, 8'h00, 1'b0);
    chk("w_valid_at1", int'(vo1), 1);
    s1(1'b1, dn++, 1'b1);
    s1(1'b1, dn++, 1'b0);
    s1(1'b1, dn++, 1'b0);
    s1(1'b0, 8'h00, 1'b0);
    chk("w_full_count", int'(cnt1), 3);
    chk("w_valid_at3", int'(vo1), 1);
    s1(1'b1, dn++, 1'b1);
    for (int k = 0; k < 30; k++) s1(1'($urandom_range(1)), dn++, 1'($urandom_range(1)));
    for (int k = 0; k < 8; k++) s1(1'b0, 8'h00, 1'b1);
    chk("w_drained", q1.size(), 0);

    s0(1'b1, 8'h11, 1'b0);
    s0(1'b1, 8'h22, 1'b0);
    s0(1'b1, 8'h33, 1'b0);
    chk("mid_count_before", int'(cnt0), 3);
    v0 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_async_count", int'(cnt0), 0);
    chk("mid_async_valid", int'(vo0), 0);
    chk("mid_async_ready", int'(ro0), 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    s0(1'b1, 8'h7E, 1'b0);
    s0(1'b0, 8'h00, 1'b0);
    chk("mid_after_valid", int'(vo0), 1);
    chk("mid_after_data", int'(do0), 8'h7E);
    chk("mid_after_count", int'(cnt0), 1);
    s0(1'b0, 8'h00, 1'b1);
    chk("mid_final_count", int'(cnt0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
